counter_ctrl: RTL and testbench

COUNTER_CTRL -- requirements
Module: counter_ctrl

---
 rtl/counter_ctrl_pkg.sv | 19 +
 rtl/btn_debounce.sv | 55 +++++
 rtl/counter_ctrl.sv | 129 ++++++++++++
 tb/tb_counter_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/counter_ctrl_pkg.sv
// Shared types and default timing for the push-button counter controller.
package counter_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HOLD     = 2'd1,
        ST_REPEAT   = 2'd2,
        ST_WAIT_REL = 2'd3
    } state_e;

    localparam int DEB_CYC_DEF = 4;
    localparam int REP_DLY_DEF = 16;
    localparam int REP_PER_DEF = 8;

    function automatic int timer_width(input int dly, input int per);
        return $clog2(((dly > per) ? dly : per) + 1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus stable-level debouncer for one active-low button.
module btn_debounce
    import counter_ctrl_pkg::*;
#(
    parameter int DEB_CYC = DEB_CYC_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic level_o
);

    localparam int              CNT_W   = $clog2(DEB_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYC - 1);

    logic             meta_q;
    logic             sync_q;
    logic             lvl_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             deb_q;
    logic             deb_d;

    // lvl_q holds the previous synchronized sample; cnt_q counts how long it has matched.
    always_comb begin
        cnt_d = cnt_q;
        deb_d = deb_q;
        if (sync_q != lvl_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            deb_d = lvl_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            lvl_q  <= 1'b1;
            cnt_q  <= '0;
            deb_q  <= 1'b1;
        end else begin
            meta_q <= btn_i;
            sync_q <= meta_q;
            lvl_q  <= sync_q;
            cnt_q  <= cnt_d;
            deb_q  <= deb_d;
        end
    end

    assign level_o = deb_q;

endmodule

// File: rtl/counter_ctrl.sv
// Up/down/clear strobe generator with press-and-hold auto-repeat for two buttons.
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int DEB_CYC = DEB_CYC_DEF,
    parameter int REP_DLY = REP_DLY_DEF,
    parameter int REP_PER = REP_PER_DEF
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [1:0] Push,
    output logic       Up_o,
    output logic       Dn_o,
    output logic       Clr_o,
    output logic [1:0] State_o
);

    localparam int               TMR_W  = timer_width(REP_DLY, REP_PER);
    localparam logic [TMR_W-1:0] DLY_LD = TMR_W'(REP_DLY);
    localparam logic [TMR_W-1:0] PER_LD = TMR_W'(REP_PER);
    localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1);

    logic up_lvl;
    logic dn_lvl;
    logic up_press;
    logic dn_press;
    logic act_press;
    logic oth_press;

    state_e           state_q, state_d;
    logic             act_up_q, act_up_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             up_q, up_d;
    logic             dn_q, dn_d;
    logic             clr_q, clr_d;

    btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_up (
        .clk_i   (Clk),
        .rst_ni  (Rst),
        .btn_i   (Push[1]),
        .level_o (up_lvl)
    );

    btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_dn (
        .clk_i   (Clk),
        .rst_ni  (Rst),
        .btn_i   (Push[0]),
        .level_o (dn_lvl)
    );

    assign up_press = ~up_lvl;
    assign dn_press = ~dn_lvl;

    always_comb begin
        state_d   = state_q;
        act_up_d  = act_up_q;
        timer_d   = timer_q;
        up_d      = 1'b0;
        dn_d      = 1'b0;
        clr_d     = 1'b0;
        act_press = act_up_q ? up_press : dn_press;
        oth_press = act_up_q ? dn_press : up_press;

        unique case (state_q)
            ST_IDLE: begin
                if (up_press && dn_press) begin
                    clr_d   = 1'b1;
                    state_d = ST_WAIT_REL;
                end else if (up_press || dn_press) begin
                    up_d     = up_press;
                    dn_d     = dn_press;
                    act_up_d = up_press;
                    timer_d  = DLY_LD;
                    state_d  = ST_HOLD;
                end
            end
            ST_HOLD, ST_REPEAT: begin
                // Release beats the other button, which beats timer expiry.
                if (!act_press) begin
                    timer_d = '0;
                    state_d = ST_IDLE;
                end else if (oth_press) begin
                    timer_d = '0;
                    state_d = ST_WAIT_REL;
                end else if (timer_q == TMR_ONE) begin
                    // Expiry is the decrement that would hit zero, so the gap equals the load value.
                    up_d    = act_up_q;
                    dn_d    = ~act_up_q;
                    timer_d = PER_LD;
                    state_d = ST_REPEAT;
                end else begin
                    timer_d = timer_q - TMR_ONE;
                end
            end
            ST_WAIT_REL: begin
                if (!up_press && !dn_press) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q  <= ST_IDLE;
            act_up_q <= 1'b0;
            timer_q  <= '0;
            up_q     <= 1'b0;
            dn_q     <= 1'b0;
            clr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            act_up_q <= act_up_d;
            timer_q  <= timer_d;
            up_q     <= up_d;
            dn_q     <= dn_d;
            clr_q    <= clr_d;
        end
    end

    assign Up_o    = up_q;
    assign Dn_o    = dn_q;
    assign Clr_o   = clr_q;
    assign State_o = state_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl: debounce latency, repeat timing, clear, conflict and reset abort.
module tb_counter_ctrl;

    logic       Clk = 1'b0;
    logic       Rst;
    logic [1:0] Push;
    logic       Up_o;
    logic       Dn_o;
    logic       Clr_o;
    logic [1:0] State_o;
    logic [2:0] strb;

    int tests = 0;
    int fails = 0;
    int dn_pulses;

    always #5 Clk = ~Clk;

    assign strb = {Up_o, Dn_o, Clr_o};

    counter_ctrl #(.DEB_CYC(4), .REP_DLY(16), .REP_PER(8)) dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .Push    (Push),
        .Up_o    (Up_o),
        .Dn_o    (Dn_o),
        .Clr_o   (Clr_o),
        .State_o (State_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic settle();
        Push = 2'b11;
        repeat (12) tick();
        chk("settle_idle", State_o, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst  = 1'b0;
        Push = 2'b11;
        repeat (3) @(negedge Clk);
        chk("rst_state", State_o, 0);
        chk("rst_strobes", strb, 0);
        Rst = 1'b1;
        settle();

        // Short up press: 12 sampled cycles low, one Up_o at cycle 7.
        Push = 2'b01;
        for (int k = 0; k < 22; k++) begin
            if (k == 12) Push = 2'b11;
            tick();
            chk("A_strobe", strb, (k == 7) ? 3'b100 : 3'b000);
            if (k == 8) chk("A_hold", State_o, 1);
        end
        chk("A_idle", State_o, 0);
        settle();

        // Bounce on the down button never survives the debouncer.
        for (int k = 0; k < 22; k++) begin
            Push = {1'b1, (k < 12) ? k[1] : 1'b1};
            tick();
            chk("B_strobe", strb, 0);
            chk("B_state", State_o, 0);
        end
        settle();

        // Hold down: strobes at 7, then +16, then every 8.
        dn_pulses = 0;
        Push = 2'b10;
        for (int k = 0; k < 45; k++) begin
            tick();
            dn_pulses += int'(Dn_o);
            chk("C_strobe", strb,
                (k == 7 || k == 23 || k == 31 || k == 39) ? 3'b010 : 3'b000);
        end
        chk("C_pulses", dn_pulses, 4);
        chk("C_repeat", State_o, 2);
        Push = 2'b11;
        repeat (7) tick();
        chk("C_not_yet", State_o, 2);
        tick();
        chk("C_idle", State_o, 0);
        settle();

        // Both pressed together: one Clr_o, then wait for full release.
        Push = 2'b00;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("D_strobe", strb, (k == 7) ? 3'b001 : 3'b000);
        end
        chk("D_wait", State_o, 3);
        Push = 2'b01;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("D_up_strobe", strb, 0);
            chk("D_up_state", State_o, 3);
        end
        Push = 2'b11;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("D_rel_strobe", strb, 0);
            if (k == 6) chk("D_rel_wait", State_o, 3);
        end
        chk("D_idle", State_o, 0);
        settle();

        // Conflict: up into REPEAT, then down as well.
        Push = 2'b01;
        for (int k = 0; k < 26; k++) begin
            tick();
            chk("E_strobe", strb, (k == 7 || k == 23) ? 3'b100 : 3'b000);
        end
        chk("E_repeat", State_o, 2);
        Push = 2'b00;
        for (int k = 26; k < 33; k++) begin
            tick();
            chk("E_pre_strobe", strb, (k == 31) ? 3'b100 : 3'b000);
        end
        chk("E_pre_state", State_o, 2);
        for (int k = 33; k < 51; k++) begin
            tick();
            chk("E_conf_strobe", strb, 0);
            chk("E_conf_state", State_o, 3);
        end
        Push = 2'b01;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("E_dnrel_strobe", strb, 0);
            chk("E_dnrel_state", State_o, 3);
        end
        settle();

        // Reset in REPEAT while Up_o is high, then the held button restarts.
        Push = 2'b01;
        for (int k = 0; k < 32; k++) begin
            tick();
            chk("F_strobe", strb, (k == 7 || k == 23 || k == 31) ? 3'b100 : 3'b000);
        end
        chk("F_repeat", State_o, 2);
        Rst = 1'b0;
        #1;
        chk("F_rst_strobe", strb, 0);
        chk("F_rst_state", State_o, 0);
        @(negedge Clk);
        Rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("F_after", strb, (k == 7) ? 3'b100 : 3'b000);
        end
        chk("F_hold", State_o, 1);
        settle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
